// File: rtl/chacha20_pkg.sv
// rtl/chacha20_pkg.sv - ChaCha20 shared word/state types, sigma constants and round index tables
//   WORD_W          : datapath word width (32)
//   SIGMA0..SIGMA3  : "expand 32-byte k" constant words 0..3
//   state_t         : 16-word packed state, word k at bits [32k+31:32k]
//   COL_IDX/DIAG_IDX: state word indices (a,b,c,d) for the four quarter-rounds
package chacha20_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [15:0]      state_t;
  typedef logic [3:0]        idx_t;

  localparam word_t SIGMA0 = 32'h61707865;
  localparam word_t SIGMA1 = 32'h3320646e;
  localparam word_t SIGMA2 = 32'h79622d32;
  localparam word_t SIGMA3 = 32'h6b206574;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } fsm_e;

  localparam idx_t COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam idx_t DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic word_t rotl(input word_t x, input int unsigned n);
    rotl = (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha20_qr.sv
// rtl/chacha20_qr.sv - Combinational ChaCha20 quarter-round on four words
//   a_i..d_i : input words
//   a_o..d_o : quarter-round results
module chacha20_qr
  import chacha20_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  input  word_t c_i,
  input  word_t d_i,
  output word_t a_o,
  output word_t b_o,
  output word_t c_o,
  output word_t d_o
);

  word_t a1, b1, c1, d1;

  always_comb begin
    a1  = a_i + b_i;
    d1  = rotl(d_i ^ a1, 16);
    c1  = c_i + d1;
    b1  = rotl(b_i ^ c1, 12);
    a_o = a1 + b1;
    d_o = rotl(d1 ^ a_o, 8);
    c_o = c1 + d_o;
    b_o = rotl(b1 ^ c_o, 7);
  end

endmodule

// File: rtl/chacha20_block_core.sv
// rtl/chacha20_block_core.sv - Iterative ChaCha20 block function, one round per cycle
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (key_i, nonce_i, counter_i sampled on acceptance)
//   in_next             : only with CHACHA20_BLK_CNT_INC_EN; reuse last key/nonce, counter+1
//   key_i               : 256-bit key, word 4+k at bits [32k+31:32k]
//   nonce_i             : 96-bit nonce, word 13+k at bits [32k+31:32k]
//   counter_i           : block counter, state word 12
//   out_valid/out_ready : keystream handshake
//   block_o             : 512-bit keystream, word k at bits [32k+31:32k]
//   NUM_ROUNDS must be even and >= 2.
module chacha20_block_core #(
  parameter int NUM_ROUNDS = 20,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef CHACHA20_BLK_CNT_INC_EN
  input  logic                  in_next,
`endif
  input  logic [8*WORD_W-1:0]   key_i,
  input  logic [3*WORD_W-1:0]   nonce_i,
  input  logic [WORD_W-1:0]     counter_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORD_W-1:0]  block_o
);

  import chacha20_pkg::*;

  localparam int CNT_W = $clog2(NUM_ROUNDS);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_RND = cnt_t'(NUM_ROUNDS - 1);

  fsm_e   state_q, state_d;
  cnt_t   rnd_cnt_q, rnd_cnt_d;
  state_t init_q, init_d;
  state_t work_q, work_d;
  state_t block_q, block_d;
  state_t load_vec, round_res;
  word_t [3:0][3:0] qr_in, qr_out;
  logic   diag;
  logic   accept;

  logic [8*WORD_W-1:0] key_sel;
  logic [3*WORD_W-1:0] nonce_sel;
  logic [WORD_W-1:0]   ctr_sel;

  assign accept = in_valid & in_ready;

`ifdef CHACHA20_BLK_CNT_INC_EN
  logic [8*WORD_W-1:0] last_key_q;
  logic [3*WORD_W-1:0] last_nonce_q;
  logic [WORD_W-1:0]   last_ctr_q;

  always_comb begin
    key_sel   = in_next ? last_key_q   : key_i;
    nonce_sel = in_next ? last_nonce_q : nonce_i;
    ctr_sel   = in_next ? last_ctr_q + 1'b1 : counter_i;
  end

  // Remember what was actually used, so a chain of in_next requests keeps counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_key_q   <= '0;
      last_nonce_q <= '0;
      last_ctr_q   <= '0;
    end else if (accept) begin
      last_key_q   <= key_sel;
      last_nonce_q <= nonce_sel;
      last_ctr_q   <= ctr_sel;
    end
  end
`else
  assign key_sel   = key_i;
  assign nonce_sel = nonce_i;
  assign ctr_sel   = counter_i;
`endif

  always_comb begin
    load_vec     = '0;
    load_vec[0]  = SIGMA0;
    load_vec[1]  = SIGMA1;
    load_vec[2]  = SIGMA2;
    load_vec[3]  = SIGMA3;
    for (int k = 0; k < 8; k++) load_vec[4+k] = key_sel[32*k +: 32];
    load_vec[12] = ctr_sel;
    for (int k = 0; k < 3; k++) load_vec[13+k] = nonce_sel[32*k +: 32];
  end

  // Even round count = column round, odd = diagonal round.
  assign diag = rnd_cnt_q[0];

  always_comb begin
    qr_in = '0;
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < 4; k++) begin
        qr_in[q][k] = diag ? work_q[DIAG_IDX[q][k]] : work_q[COL_IDX[q][k]];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha20_qr u_qr (
      .a_i (qr_in[g][0]),
      .b_i (qr_in[g][1]),
      .c_i (qr_in[g][2]),
      .d_i (qr_in[g][3]),
      .a_o (qr_out[g][0]),
      .b_o (qr_out[g][1]),
      .c_o (qr_out[g][2]),
      .d_o (qr_out[g][3])
    );
  end

  // Each index table covers all 16 words exactly once, so the scatter is total.
  always_comb begin
    round_res = work_q;
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < 4; k++) begin
        if (diag) round_res[DIAG_IDX[q][k]] = qr_out[q][k];
        else      round_res[COL_IDX[q][k]]  = qr_out[q][k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rnd_cnt_d = rnd_cnt_q;
    init_d    = init_q;
    work_d    = work_q;
    block_d   = block_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          init_d    = load_vec;
          work_d    = load_vec;
          rnd_cnt_d = '0;
          state_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        work_d    = round_res;
        rnd_cnt_d = rnd_cnt_q + 1'b1;
        if (rnd_cnt_q == LAST_RND) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        for (int k = 0; k < 16; k++) block_d[k] = work_q[k] + init_q[k];
        state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_cnt_q <= '0;
      init_q    <= '0;
      work_q    <= '0;
      block_q   <= '0;
    end else begin
      rnd_cnt_q <= rnd_cnt_d;
      init_q    <= init_d;
      work_q    <= work_d;
      block_q   <= block_d;
    end
  end

  assign block_o = block_q;

endmodule
